regfile_mp: RTL

- Parametrised successor to the CPU's 8-entry register file: configurable word width, register count and special-register indices.
- Adds asynchronous reset, a write-first read bypass, a fixed write-priority scheme and a bounded hardware stack pointer with push/pop and sticky overflow/underflow flags.
- Sits between decode (read fetch) and writeback/flag logic in the graph-traversal CPU.

---
 rtl/regfile_mp.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first read bypass, prioritised
// special-register writes and a bounded hardware stack pointer with sticky error flags.
module regfile_mp #(
    parameter int               WIDTH       = 32,
    parameter int               NREGS       = 8,
    parameter int               AW          = 3,
    parameter int               SREG_IDX    = 5,
    parameter int               RN_IDX      = 6,
    parameter int               SP_IDX      = 7,
    parameter logic [WIDTH-1:0] STACK_BASE  = WIDTH'(32'h0000_0100),
    parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(32'h0000_00C0)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic [WIDTH-1:0] sreg_rd,
    output logic [WIDTH-1:0] sp_rd,
    output logic [WIDTH-1:0] rn_rd,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flag_we,
    input  logic [WIDTH-1:0] flag_wdata,
    input  logic             rn_we,
    input  logic [WIDTH-1:0] rn_wdata,
    input  logic             sp_we,
    input  logic [WIDTH-1:0] sp_wdata,
    input  logic             sp_push,
    input  logic             sp_pop,
    input  logic             err_clr,
    output logic             stk_ovf,
    output logic             stk_unf
);

    logic [WIDTH-1:0] regs_reg  [NREGS];
    logic [WIDTH-1:0] regs_next [NREGS];

    logic [WIDTH-1:0] sp_cur;
    logic             push_only;
    logic             pop_only;
    logic             ovf_evt;
    logic             unf_evt;
    logic             stk_ovf_next;
    logic             stk_unf_next;

    assign sp_cur    = regs_reg[SP_IDX];
    assign push_only = sp_push & ~sp_pop & ~sp_we;
    assign pop_only  = sp_pop & ~sp_push & ~sp_we;
    assign ovf_evt   = push_only & (sp_cur == STACK_LIMIT);
    assign unf_evt   = pop_only & (sp_cur == STACK_BASE);

    // A fresh error in the same cycle as err_clr must leave the flag set.
    assign stk_ovf_next = (stk_ovf & ~err_clr) | ovf_evt;
    assign stk_unf_next = (stk_unf & ~err_clr) | unf_evt;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic wr_hit;
            assign wr_hit = wr_en && (wr_addr == AW'(gi));

            if (gi == SP_IDX) begin : g_sp
                // Any push/pop request owns SP that cycle, even one refused at a bound.
                assign regs_next[gi] = sp_we                                ? sp_wdata :
                                       (push_only && !ovf_evt)              ? sp_cur - WIDTH'(1) :
                                       (pop_only && !unf_evt)               ? sp_cur + WIDTH'(1) :
                                       (sp_push || sp_pop)                  ? sp_cur :
                                       wr_hit                               ? wr_data :
                                                                              regs_reg[gi];
            end else if (gi == RN_IDX) begin : g_rn
                assign regs_next[gi] = rn_we  ? rn_wdata :
                                       wr_hit ? wr_data  : regs_reg[gi];
            end else if (gi == SREG_IDX) begin : g_sreg
                assign regs_next[gi] = flag_we ? flag_wdata :
                                       wr_hit  ? wr_data    : regs_reg[gi];
            end else begin : g_gen
                assign regs_next[gi] = wr_hit ? wr_data : regs_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= (i == SP_IDX) ? STACK_BASE : '0;
            end
            rd_data1 <= '0;
            rd_data2 <= '0;
            sreg_rd  <= '0;
            sp_rd    <= STACK_BASE;
            rn_rd    <= '0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= regs_next[i];
            end
            stk_ovf <= stk_ovf_next;
            stk_unf <= stk_unf_next;
            // Reads sample next-state values so same-cycle writes are visible.
            if (rd_en) begin
                rd_data1 <= regs_next[rd_addr1];
                rd_data2 <= regs_next[rd_addr2];
                sreg_rd  <= regs_next[SREG_IDX];
                sp_rd    <= regs_next[SP_IDX];
                rn_rd    <= regs_next[RN_IDX];
            end
        end
    end

endmodule
